// File: rtl/usbh_tx_stream_pkg.sv
// Shared definitions for the USB host TX stream reader: state encodings and CRC16 constants.
package usbh_tx_stream_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_CRC_LO = 2'd2;
    localparam logic [1:0] ST_CRC_HI = 2'd3;

    // Reflected form of x^16+x^15+x^2+1, bits shifted out LSB-first.
    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/usbh_crc16.sv
// Combinational USB CRC16 update over one byte, LSB-first; shared with the RX checker.
module usbh_crc16
    import usbh_tx_stream_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] c;

    always_comb begin
        c = crc_i;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) begin
                c = (c >> 1) ^ CRC16_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/usbh_tx_stream.sv
// Pops a len_i-byte payload from the show-ahead TX FIFO and streams it to the SIE.
// Define USBH_TX_STREAM_CRC_EN to append the inverted CRC16 (low byte first) to each packet.
module usbh_tx_stream
    import usbh_tx_stream_pkg::*;
#(
    parameter int unsigned LEN_W = 11
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    input  logic [7:0]       fifo_data_i,
    input  logic             fifo_empty_i,
    output logic             fifo_pop_o,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             last_o,
    input  logic             accept_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             underrun_o
);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             loadable;

`ifdef USBH_TX_STREAM_CRC_EN
    logic [15:0] crc_q, crc_d, crc_next;

    usbh_crc16 u_crc16 (
        .crc_i  (crc_q),
        .data_i (fifo_data_i),
        .crc_o  (crc_next)
    );
`else
    // Zero-length packets send nothing, so their done pulse comes from this flag instead.
    logic zlen_q, zlen_d;
    logic zdone_q, zdone_d;
`endif

    assign loadable = !valid_q || accept_i;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        fifo_pop_o = 1'b0;
        underrun_o = 1'b0;
`ifdef USBH_TX_STREAM_CRC_EN
        crc_d      = crc_q;
`else
        zlen_d     = zlen_q;
        zdone_d    = 1'b0;
`endif
        if (loadable) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (abort_i) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rem_d   = len_i;
                        state_d = ST_DATA;
`ifdef USBH_TX_STREAM_CRC_EN
                        crc_d   = CRC16_INIT;
`else
                        zlen_d  = (len_i == '0);
`endif
                    end
                end
                ST_DATA: begin
                    if (loadable) begin
                        if (rem_q != '0) begin
                            if (!fifo_empty_i) begin
                                fifo_pop_o = 1'b1;
                                data_d     = fifo_data_i;
                                valid_d    = 1'b1;
                                rem_d      = rem_q - 1'b1;
`ifdef USBH_TX_STREAM_CRC_EN
                                crc_d      = crc_next;
`else
                                last_d     = (rem_q == LEN_W'(1));
`endif
                            end else begin
                                underrun_o = 1'b1;
                                state_d    = ST_IDLE;
                            end
                        end else begin
`ifdef USBH_TX_STREAM_CRC_EN
                            state_d = ST_CRC_LO;
`else
                            state_d = ST_IDLE;
                            zdone_d = zlen_q;
`endif
                        end
                    end
                end
`ifdef USBH_TX_STREAM_CRC_EN
                ST_CRC_LO: begin
                    if (loadable) begin
                        data_d  = ~crc_q[7:0];
                        valid_d = 1'b1;
                        state_d = ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    if (loadable) begin
                        data_d  = ~crc_q[15:8];
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef USBH_TX_STREAM_CRC_EN
            crc_q   <= CRC16_INIT;
`else
            zlen_q  <= 1'b0;
            zdone_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
`ifdef USBH_TX_STREAM_CRC_EN
            crc_q   <= crc_d;
`else
            zlen_q  <= zlen_d;
            zdone_q <= zdone_d;
`endif
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = (state_q != ST_IDLE);
`ifdef USBH_TX_STREAM_CRC_EN
    assign done_o  = valid_q && last_q && accept_i && !abort_i;
`else
    assign done_o  = ((valid_q && last_q && accept_i) || zdone_q) && !abort_i;
`endif

endmodule

// File: tb/tb_usbh_tx_stream.sv
// Directed bench for usbh_tx_stream with a FIFO model and an expected-byte scoreboard.
// Expectations follow USBH_TX_STREAM_CRC_EN when the bench is compiled with it defined.
module tb_usbh_tx_stream;

`ifdef USBH_TX_STREAM_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int unsigned LEN_W = 11;

    logic             clk_i = 1'b0;
    logic             n_rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic             abort_i = 1'b0;
    logic [7:0]       fifo_data_i = '0;
    logic             fifo_empty_i = 1'b1;
    logic             fifo_pop_o;
    logic [7:0]       data_o;
    logic             valid_o;
    logic             last_o;
    logic             accept_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic             underrun_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned pop_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned ur_cnt = 0;
    logic        held_v = 1'b0;
    logic [7:0]  held_d = '0;
    logic [7:0]  fifo_m [$];
    logic [8:0]  exp_q [$];

    usbh_tx_stream #(.LEN_W(LEN_W)) dut (
        .clk_i        (clk_i),
        .n_rst_i      (n_rst_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .abort_i      (abort_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_pop_o   (fifo_pop_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .last_o       (last_o),
        .accept_i     (accept_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .underrun_o   (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [7:0] bytes [$]);
        logic [15:0] c = 16'hFFFF;
        foreach (bytes[k]) begin
            for (int b = 0; b < 8; b++) begin
                logic fb = c[0] ^ bytes[k][b];
                c = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic fifo_refresh();
        fifo_empty_i = (fifo_m.size() == 0);
        fifo_data_i  = (fifo_m.size() != 0) ? fifo_m[0] : 8'h00;
    endtask

    task automatic fifo_push(input logic [7:0] b);
        fifo_m.push_back(b);
        fifo_refresh();
    endtask

    // Expected stream for a packet: payload bytes, then the CRC pair when enabled.
    task automatic expect_pkt(input logic [7:0] pay [$], input bit complete);
        logic [15:0] c;
        foreach (pay[k])
            exp_q.push_back({complete && !CRC_EN && (k == pay.size() - 1), pay[k]});
        if (complete && CRC_EN) begin
            c = ~crc_model(pay);
            exp_q.push_back({1'b0, c[7:0]});
            exp_q.push_back({1'b1, c[15:8]});
        end
    endtask

    task automatic tick();
        logic v, a, l, dn, ur, pop;
        logic [7:0] d;
        logic [8:0] e;
        #1;
        v = valid_o; a = accept_i; l = last_o; d = data_o;
        dn = done_o; ur = underrun_o; pop = fifo_pop_o;
        if (pop) begin
            pop_cnt++;
            check("pop_while_empty", {31'd0, fifo_empty_i}, 32'd0);
        end
        if (held_v && v) check("hold_stable", {24'd0, d}, {24'd0, held_d});
        held_v = v && !a;
        held_d = d;
        if (v && a) begin
            check("stream_extra", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stream_byte", {23'd0, l, d}, {23'd0, e});
            end
        end
        if (dn) done_cnt++;
        if (ur) ur_cnt++;
        @(posedge clk_i);
        #1;
        if (pop && fifo_m.size() != 0) void'(fifo_m.pop_front());
        fifo_refresh();
        if (ur) check("busy_after_underrun", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run_until_idle(input string tag, input int unsigned max);
        int unsigned c = 0;
        while ((busy_o || valid_o) && c < max) begin
            tick();
            c++;
        end
        check(tag, {31'd0, busy_o || valid_o}, 32'd0);
        tick();
        tick();
    endtask

    task automatic clear_counts();
        pop_cnt = 0; done_cnt = 0; ur_cnt = 0;
    endtask

    task automatic start_pkt(input int unsigned n);
        len_i   = LEN_W'(n);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        logic [7:0] pay [$];
        fifo_refresh();
        #2;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_busy",  {31'd0, busy_o}, 32'd0);
        check("rst_outs",  {21'd0, fifo_pop_o, done_o, underrun_o, last_o, data_o}, 32'd0);
        @(posedge clk_i); #1;
        n_rst_i = 1'b1;
        tick();

        // 1: three-byte packet, continuous accept
        clear_counts();
        accept_i = 1'b1;
        pay = '{8'h01, 8'h02, 8'h03};
        foreach (pay[k]) fifo_push(pay[k]);
        expect_pkt(pay, 1'b1);
        start_pkt(3);
        check("t1_no_valid_1cyc", {31'd0, valid_o}, 32'd0);
        tick();
        check("t1_valid_2cyc", {31'd0, valid_o}, 32'd1);
        check("t1_first_byte", {24'd0, data_o}, 32'h01);
        run_until_idle("t1_timeout", 40);
        check("t1_pops", pop_cnt, 32'd3);
        check("t1_done", done_cnt, 32'd1);
        check("t1_stream_left", exp_q.size(), 32'd0);

        // 2: zero-length packet
        clear_counts();
        pay = {};
        expect_pkt(pay, 1'b1);
        start_pkt(0);
        run_until_idle("t2_timeout", 40);
        check("t2_pops", pop_cnt, 32'd0);
        check("t2_done", done_cnt, 32'd1);
        check("t2_stream_left", exp_q.size(), 32'd0);

        // 3: FIFO runs dry mid-packet
        clear_counts();
        pay = '{8'hAA, 8'hBB};
        foreach (pay[k]) fifo_push(pay[k]);
        expect_pkt(pay, 1'b0);
        start_pkt(4);
        run_until_idle("t3_timeout", 40);
        check("t3_underrun", ur_cnt, 32'd1);
        check("t3_done", done_cnt, 32'd0);
        check("t3_pops", pop_cnt, 32'd2);
        check("t3_stream_left", exp_q.size(), 32'd0);

        // 4: accept toggling on a 5-byte packet
        clear_counts();
        pay = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        foreach (pay[k]) fifo_push(pay[k]);
        expect_pkt(pay, 1'b1);
        accept_i = 1'b0;
        start_pkt(5);
        for (int unsigned c = 0; c < 80 && (busy_o || valid_o); c++) begin
            accept_i = ~accept_i;
            tick();
        end
        check("t4_timeout", {31'd0, busy_o || valid_o}, 32'd0);
        accept_i = 1'b1;
        tick();
        check("t4_pops", pop_cnt, 32'd5);
        check("t4_done", done_cnt, 32'd1);
        check("t4_stream_left", exp_q.size(), 32'd0);

        // 5: abort while the second payload byte is presented, then a fresh 1-byte packet
        clear_counts();
        pay = '{8'h21, 8'h22, 8'h23, 8'h24};
        foreach (pay[k]) fifo_push(pay[k]);
        pay = '{8'h21};
        expect_pkt(pay, 1'b0);
        start_pkt(3);
        tick();
        tick();
        check("t5_second_byte", {24'd0, data_o}, 32'h22);
        abort_i  = 1'b1;
        accept_i = 1'b0;
        #1;
        check("t5_abort_no_pop", {31'd0, fifo_pop_o}, 32'd0);
        tick();
        abort_i  = 1'b0;
        accept_i = 1'b1;
        check("t5_abort_valid", {30'd0, valid_o, last_o}, 32'd0);
        check("t5_abort_busy", {31'd0, busy_o}, 32'd0);
        tick();
        pay = '{8'h23};
        expect_pkt(pay, 1'b1);
        start_pkt(1);
        run_until_idle("t5_timeout", 40);
        check("t5_pops", pop_cnt, 32'd3);
        check("t5_done", done_cnt, 32'd1);
        check("t5_stream_left", exp_q.size(), 32'd0);
        fifo_m = {};
        fifo_refresh();

        // 6: asynchronous reset once the payload is out, then start_i held while busy
        clear_counts();
        pay = '{8'h31, 8'h32};
        foreach (pay[k]) fifo_push(pay[k]);
        expect_pkt(pay, !CRC_EN);
        start_pkt(2);
        tick();
        tick();
        tick();
        n_rst_i = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t6_rst_outs", {21'd0, valid_o, fifo_pop_o, done_o, underrun_o, last_o, data_o}, 32'd0);
        tick();
        n_rst_i = 1'b1;
        tick();
        check("t6_idle_after_rst", {31'd0, busy_o}, 32'd0);
        check("t6_stream_left", exp_q.size(), 32'd0);
        exp_q = {};
        clear_counts();
        pay = '{8'h41, 8'h42, 8'h43};
        foreach (pay[k]) fifo_push(pay[k]);
        expect_pkt(pay, 1'b1);
        start_pkt(3);
        len_i   = LEN_W'(1);
        start_i = 1'b1;
        tick();
        tick();
        start_i = 1'b0;
        run_until_idle("t6_timeout", 40);
        check("t6_pops", pop_cnt, 32'd3);
        check("t6_done", done_cnt, 32'd1);
        check("t6_stream_left", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
